// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 16-bit pipeline.
// Requests instructions from instruction memory and presents (pc, instruction)
// to the IF/ID register. One output slot plus one skid entry absorb a stall
// without losing or repeating an instruction. Redirects flush both and may land
// while a memory request is still outstanding; in that case the old request is
// drained before the new target is requested.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] tgt_q, tgt_d;

    logic consume;
    logic slot_free;

    assign consume   = valid_q & ~stall;
    assign slot_free = ~valid_q | consume;

    // Next-state logic: a redirect flushes the slot and skid and overrides stall/consume.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        tgt_d        = tgt_q;

        if (redirect) begin
            valid_d      = 1'b0;
            pc_d         = 16'h0000;
            instr_d      = 16'h0000;
            skid_pc_d    = 16'h0000;
            skid_instr_d = 16'h0000;
            case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        addr_d = redirect_pc;
                    end else begin
                        tgt_d   = redirect_pc;
                        state_d = DRAIN;
                    end
                end
                HOLD: begin
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    state_d = FETCH;
                end
                DRAIN: begin
                    tgt_d = redirect_pc;
                    if (imem_ack) begin
                        addr_d  = redirect_pc;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = RESET_PC;
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (slot_free) begin
                            pc_d    = addr_q;
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                        end else begin
                            skid_pc_d    = addr_q;
                            skid_instr_d = imem_rdata;
                            req_d        = 1'b0;
                            state_d      = HOLD;
                        end
                        addr_d = addr_q + PC_INC;
                    end else if (consume) begin
                        valid_d = 1'b0;
                        pc_d    = 16'h0000;
                        instr_d = 16'h0000;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        pc_d    = skid_pc_q;
                        instr_d = skid_instr_q;
                        valid_d = 1'b1;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        valid_d = 1'b0;
                        pc_d    = 16'h0000;
                        instr_d = 16'h0000;
                    end
                    if (imem_ack) begin
                        addr_d  = tgt_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset clears the outputs immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            pc_q         <= 16'h0000;
            instr_q      <= 16'h0000;
            valid_q      <= 1'b0;
            skid_pc_q    <= 16'h0000;
            skid_instr_q <= 16'h0000;
            tgt_q        <= 16'h0000;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            tgt_q        <= tgt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign fetch_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The reference model is the program-order stream IF/ID should accept: it
// starts at the reset PC, advances by 2 per accepted instruction and restarts at
// the target of every redirect. Stimulus pushes that stream into a queue; the
// monitor pops one entry for every edge at which IF/ID accepts an instruction.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        fetch_valid;

    int compared   = 0;
    int mismatched = 0;
    int consumes   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model_next;

    bit          mem_random = 1'b0;
    int          mem_delay  = 0;
    int          mem_left   = -1;

    logic        prev_wait  = 1'b0;
    logic        prev_rst   = 1'b0;
    logic [15:0] prev_addr  = 16'h0000;
    logic [15:0] exp_pc;

    fetch_unit #(
        .RESET_PC(16'h0000),
        .PC_INC  (16'd2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instruction(instruction),
        .fetch_valid(fetch_valid)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: every address holds a unique word.
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'hA000;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushRun(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_next);
            model_next = model_next + 16'd2;
        end
    endtask

    task automatic restartModel(input logic [15:0] start);
        exp_q.delete();
        model_next = start;
        pushRun(32);
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        if (r) restartModel(rpc);
        if (exp_q.size() < 16) pushRun(32);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    // Memory model: answers each request after 0..2 cycles; ack may coincide with the request rise.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req) begin
                imem_ack   = 1'b0;
                imem_rdata = 16'hDEAD;
                mem_left   = -1;
            end else begin
                if (mem_left < 0) mem_left = mem_random ? int'($urandom_range(0, 2)) : mem_delay;
                if (mem_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_data(imem_addr);
                    mem_left   = -1;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 16'hDEAD;
                    mem_left--;
                end
            end
        end
    end

    // Monitor: pops the expected stream on every accepting edge and checks interface rules.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && prev_rst) begin
                if (!fetch_valid) begin
                    checkOutput("bubble_pc", pc, 16'h0000);
                    checkOutput("bubble_instr", instruction, 16'h0000);
                end
                if (prev_wait) checkOutput("addr_stable", imem_addr, prev_addr);
                if (fetch_valid && !stall && !redirect) begin
                    consumes++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL stream_empty: got pc 0x%04h, expected no output", pc);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        checkOutput("stream_pc", pc, exp_pc);
                        checkOutput("stream_instr", instruction, mem_data(exp_pc));
                    end
                end
            end
            prev_wait = rst_n && imem_req && !imem_ack;
            prev_addr = imem_addr;
            prev_rst  = rst_n;
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        restartModel(16'h0000);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_req", 16'(imem_req), 16'h0000);
        checkOutput("rst_addr", imem_addr, 16'h0000);
        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_instr", instruction, 16'h0000);
        checkOutput("rst_valid", 16'(fetch_valid), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        waitCycle();
        checkOutput("first_req", 16'(imem_req), 16'h0001);
        checkOutput("first_addr", imem_addr, 16'h0000);
        waitCycle();
        checkOutput("seq_pc0", pc, 16'h0000);
        checkOutput("seq_instr0", instruction, 16'hA000);
        checkOutput("seq_valid0", 16'(fetch_valid), 16'h0001);
        waitCycle();
        checkOutput("seq_pc2", pc, 16'h0002);
        waitCycle();
        checkOutput("seq_pc4", pc, 16'h0004);
        checkOutput("seq_instr4", instruction, 16'hA004);

        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycle();
        checkOutput("stall_pc_a", pc, 16'h0004);
        checkOutput("stall_req_drop", 16'(imem_req), 16'h0000);
        checkOutput("stall_addr", imem_addr, 16'h0008);
        waitCycle();
        checkOutput("stall_pc_b", pc, 16'h0004);
        waitCycle();
        checkOutput("stall_pc_c", pc, 16'h0004);
        checkOutput("stall_instr_c", instruction, 16'hA004);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        mem_delay = 2;
        waitCycle();
        checkOutput("skid_pc", pc, 16'h0006);
        checkOutput("skid_instr", instruction, 16'hA006);
        checkOutput("resume_req", 16'(imem_req), 16'h0001);
        checkOutput("resume_addr", imem_addr, 16'h0008);

        applyStimulus(1'b0, 1'b1, 16'h0100);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("drain_valid", 16'(fetch_valid), 16'h0000);
        checkOutput("drain_addr_a", imem_addr, 16'h0008);
        waitCycle();
        mem_delay = 0;
        checkOutput("drain_addr_b", imem_addr, 16'h0008);
        checkOutput("drain_req", 16'(imem_req), 16'h0001);
        waitCycle();
        checkOutput("drain_tgt_addr", imem_addr, 16'h0100);
        checkOutput("drain_pc", pc, 16'h0000);
        waitCycle();
        checkOutput("tgt_pc", pc, 16'h0100);
        checkOutput("tgt_instr", instruction, 16'hA100);

        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycle();
        checkOutput("hold_req", 16'(imem_req), 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h0200);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("flush_valid", 16'(fetch_valid), 16'h0000);
        checkOutput("flush_addr", imem_addr, 16'h0200);
        waitCycle();
        checkOutput("flush_pc", pc, 16'h0200);
        checkOutput("flush_instr", instruction, 16'hA200);

        applyStimulus(1'b0, 1'b1, 16'h0300);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("ackredir_valid", 16'(fetch_valid), 16'h0000);
        checkOutput("ackredir_addr", imem_addr, 16'h0300);
        waitCycle();
        checkOutput("ackredir_pc", pc, 16'h0300);

        applyStimulus(1'b0, 1'b1, 16'hFFFC);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);
        waitCycle();
        checkOutput("wrap_pc_a", pc, 16'hFFFC);
        checkOutput("wrap_instr_a", instruction, 16'h5FFC);
        waitCycle();
        checkOutput("wrap_pc_b", pc, 16'hFFFE);
        waitCycle();
        checkOutput("wrap_pc_c", pc, 16'h0000);
        checkOutput("wrap_instr_c", instruction, 16'hA000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycle();
        checkOutput("hold_before_rst", 16'(imem_req), 16'h0000);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 16'(fetch_valid), 16'h0000);
        checkOutput("async_instr", instruction, 16'h0000);
        checkOutput("async_pc", pc, 16'h0000);
        checkOutput("async_req", 16'(imem_req), 16'h0000);

        repeat (2) @(posedge clk);
        #2;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        restartModel(16'h0000);
        mem_random = 1'b1;
        consumes   = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            waitCycle();
            applyStimulus(($urandom % 4) == 0, ($urandom % 16) == 0, 16'($urandom) & 16'hFFFE);
        end
        waitCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);

        compared++;
        if (consumes < 300) begin
            mismatched++;
            $display("[TB] FAIL progress: got %0d accepted instructions, expected at least 300", consumes);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
